tile_writer: RTL and testbench

- Input-side stage feeding the write port of the 64-entry x 9-bit tile memory that the VGA scan-out reads.
- Converts raw board buttons and switches into clean single-cycle memory writes, plus a cursor address.
- Supports single write with auto-increment, set-cursor, full clear, and full fill.
- Replaces the ad-hoc level-sensitive KEY/SW logic at the top level; the top level instantiates it between the board pins and the memory.

---
 rtl/tile_pkg.sv | 25 ++
 rtl/key_debounce.sv | 59 +++++
 rtl/tile_writer.sv | 156 +++++++++++++++
 tb/tb_tile_writer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
// Shared constants and types for the tile-memory writer:
//   - default tile memory geometry (address / data width, depth)
//   - board key index assignments
//   - writer FSM state encoding
// ---------------------------------------------------------------------------
package tile_pkg;

    localparam int ADDR_W_DEF = 6;   // 64-entry tile memory
    localparam int DATA_W_DEF = 9;   // 3 bits each of R, G, B
    localparam int TILE_DEPTH = 64;

    localparam int NUM_KEYS = 4;
    localparam int KEY_WR   = 0;     // single write at cursor, then cursor++
    localparam int KEY_CUR  = 1;     // load cursor from switches
    localparam int KEY_CLR  = 2;     // sweep the whole memory with zero
    localparam int KEY_FILL = 3;     // sweep the whole memory with switch data

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// One push button: 2-flop synchronizer, stability counter and debounced
// state register. Emits a single-cycle pulse when the debounced state
// goes from released (1) to pressed (0). Releases produce no pulse.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   i_key_n  in   raw active-low button, asynchronous to clk
//   o_press  out  one-cycle press pulse, aligned with the debounced change
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                // Any bounce back to the accepted level restarts the count.
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // The pulse is registered together with the state change,
                // so it is high exactly in the cycle the stable value flips.
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/tile_writer.sv
// ---------------------------------------------------------------------------
// tile_writer
// Turns board buttons and switches into clean single-cycle writes to the
// 64 x 9-bit tile memory read by the VGA scan-out.
//   KEY0: write sw[8:0] at cursor, cursor increments (wraps)
//   KEY1: cursor <= sw[5:0]
//   KEY2: clear sweep (all entries <= 0)
//   KEY3: fill sweep  (all entries <= sw[8:0], latched at the press)
// Simultaneous presses resolve KEY2 > KEY3 > KEY0 > KEY1; presses during a
// sweep are discarded.
//
// Ports:
//   clk     in   system clock (50 MHz)
//   rst     in   synchronous reset, active-high
//   key_n   in   raw buttons, active-low, asynchronous
//   sw      in   raw slide switches, quasi-static (sw[9] unused)
//   we      out  memory write enable, registered
//   wa      out  memory write address, registered, held when we=0
//   wv      out  memory write data, registered, held when we=0
//   cursor  out  current single-write address
//   busy    out  high on each write cycle of a clear/fill sweep
// ---------------------------------------------------------------------------
module tile_writer
    import tile_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        key_n,
    input  logic [9:0]        sw,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wv,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy
);

    // One past the last address: the sweep index is one bit wider so it
    // can represent this value and flag completion.
    localparam logic [ADDR_W:0] SWEEP_END = (ADDR_W + 1)'(1) << ADDR_W;

    logic [NUM_KEYS-1:0] w_press;
    logic                w_sw_unused;

    state_t              r_state,  r_state_next;
    logic [ADDR_W:0]     r_idx,    r_idx_next;
    logic [DATA_W-1:0]   r_data,   r_data_next;
    logic [ADDR_W-1:0]   r_cursor, r_cursor_next;
    logic                r_we,     r_we_next;
    logic                r_busy,   r_busy_next;
    logic [ADDR_W-1:0]   r_wa,     r_wa_next;
    logic [DATA_W-1:0]   r_wv,     r_wv_next;

    assign w_sw_unused = sw[9];

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk     (clk),
                .rst     (rst),
                .i_key_n (key_n[gi]),
                .o_press (w_press[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_data   <= '0;
            r_cursor <= '0;
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
            r_wa     <= '0;
            r_wv     <= '0;
        end else begin
            r_state  <= r_state_next;
            r_idx    <= r_idx_next;
            r_data   <= r_data_next;
            r_cursor <= r_cursor_next;
            r_we     <= r_we_next;
            r_busy   <= r_busy_next;
            r_wa     <= r_wa_next;
            r_wv     <= r_wv_next;
        end
    end

    always_comb begin
        r_state_next  = r_state;
        r_idx_next    = r_idx;
        r_data_next   = r_data;
        r_cursor_next = r_cursor;
        r_we_next     = 1'b0;
        r_busy_next   = 1'b0;
        r_wa_next     = r_wa;
        r_wv_next     = r_wv;

        case (r_state)
            IDLE: begin
                // Starting a sweep issues its address-0 write right away,
                // so the index is preloaded with 1.
                if (w_press[KEY_CLR]) begin
                    r_state_next = SWEEP;
                    r_data_next  = '0;
                    r_idx_next   = (ADDR_W + 1)'(1);
                    r_we_next    = 1'b1;
                    r_busy_next  = 1'b1;
                    r_wa_next    = '0;
                    r_wv_next    = '0;
                end else if (w_press[KEY_FILL]) begin
                    r_state_next = SWEEP;
                    r_data_next  = sw[DATA_W-1:0];
                    r_idx_next   = (ADDR_W + 1)'(1);
                    r_we_next    = 1'b1;
                    r_busy_next  = 1'b1;
                    r_wa_next    = '0;
                    r_wv_next    = sw[DATA_W-1:0];
                end else if (w_press[KEY_WR]) begin
                    r_we_next     = 1'b1;
                    r_wa_next     = r_cursor;
                    r_wv_next     = sw[DATA_W-1:0];
                    r_cursor_next = r_cursor + 1'b1;
                end else if (w_press[KEY_CUR]) begin
                    r_cursor_next = sw[ADDR_W-1:0];
                end
            end
            SWEEP: begin
                if (r_idx == SWEEP_END) begin
                    r_state_next = IDLE;
                end else begin
                    r_we_next   = 1'b1;
                    r_busy_next = 1'b1;
                    r_wa_next   = r_idx[ADDR_W-1:0];
                    r_wv_next   = r_data;
                    r_idx_next  = r_idx + 1'b1;
                end
            end
            default: begin
                r_state_next = IDLE;
            end
        endcase
    end

    assign we     = r_we;
    assign wa     = r_wa;
    assign wv     = r_wv;
    assign cursor = r_cursor;
    assign busy   = r_busy;

endmodule

// File: tb/tb_tile_writer.sv
// ---------------------------------------------------------------------------
// tb_tile_writer
// Directed bench for tile_writer with DEBOUNCE_CYCLES=4. A raw key edge
// driven in cycle 0 must produce the write in cycle 7. Every write is
// logged at the falling edge with its cycle number; scenarios compare the
// log against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_tile_writer;

    localparam int DEB = 4;
    localparam int LAT = 3 + DEB;   // raw edge -> write cycle

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_n;
    logic [9:0] sw;
    logic       we;
    logic [5:0] wa;
    logic [8:0] wv;
    logic [5:0] cursor;
    logic       busy;

    tile_writer #(
        .DEBOUNCE_CYCLES(DEB),
        .ADDR_W(6),
        .DATA_W(9)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key_n  (key_n),
        .sw     (sw),
        .we     (we),
        .wa     (wa),
        .wv     (wv),
        .cursor (cursor),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] wa;
        logic [8:0] wv;
        logic       busy;
    } wr_t;

    wr_t log_q[$];
    int  busy_cnt = 0;

    always @(negedge clk) begin
        if (we) log_q.push_back('{cyc, wa, wv, busy});
        if (busy) busy_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Press key k for 10 cycles, release, let the release settle.
    task automatic press(input int k, input logic [9:0] s, output int t0);
        @(negedge clk);
        sw       = s;
        key_n[k] = 1'b0;
        t0       = cyc;
        repeat (10) @(negedge clk);
        key_n[k] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_sweep(input string name, input int base, input int t0,
                               input logic [8:0] exp_wv);
        int  n;
        int  bad;
        wr_t e;
        n   = log_q.size() - base;
        bad = 0;
        check({name, "_count"}, n, 64);
        for (int i = 0; i < 64 && i < n; i++) begin
            e = log_q[base + i];
            if (e.wa != 6'(i) || e.wv != exp_wv || !e.busy || e.cyc != t0 + LAT + i)
                bad++;
        end
        check({name, "_bad_entries"}, bad, 0);
    endtask

    typedef struct {
        int         key;
        logic [9:0] sw;
        int         exp_writes;
        logic [5:0] exp_wa;
        logic [8:0] exp_wv;
        logic [5:0] exp_cursor;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int t0;
        int base;
        int bbase;
        int exp_cursor;

        tbl[0] = '{0, 10'h1A5, 1, 6'd0,  9'h1A5, 6'd1};
        tbl[1] = '{1, 10'h03F, 0, 6'd0,  9'h000, 6'd63};
        tbl[2] = '{0, 10'h0FF, 1, 6'd63, 9'h0FF, 6'd0};
        tbl[3] = '{0, 10'h0FF, 1, 6'd0,  9'h0FF, 6'd1};
        tbl[4] = '{1, 10'h20A, 0, 6'd0,  9'h000, 6'd10};
        tbl[5] = '{0, 10'h3C3, 1, 6'd10, 9'h1C3, 6'd11};

        rst   = 1'b1;
        key_n = 4'hF;
        sw    = 10'h000;
        repeat (3) @(negedge clk);
        check("reset_we", int'(we), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_cursor", int'(cursor), 0);
        check("reset_wa", int'(wa), 0);
        check("reset_wv", int'(wv), 0);
        rst = 1'b0;

        // Idle inputs for 100 cycles.
        base  = log_q.size();
        bbase = busy_cnt;
        repeat (100) @(negedge clk);
        check("idle_writes", log_q.size() - base, 0);
        check("idle_busy", busy_cnt - bbase, 0);
        check("idle_cursor", int'(cursor), 0);
        $display("txn idle: writes=%0d cursor=%0d", log_q.size() - base, cursor);

        // Bouncing KEY0 (2 cycles low / 2 high) never settles.
        base = log_q.size();
        sw   = 10'h1A5;
        for (int i = 0; i < 6; i++) begin
            key_n[0] = 1'b0;
            repeat (2) @(negedge clk);
            key_n[0] = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("bounce_writes", log_q.size() - base, 0);
        check("bounce_cursor", int'(cursor), 0);
        $display("txn bounce: writes=%0d cursor=%0d", log_q.size() - base, cursor);

        // Single-key transactions.
        exp_cursor = 0;
        for (int v = 0; v < 6; v++) begin
            base  = log_q.size();
            bbase = busy_cnt;
            press(tbl[v].key, tbl[v].sw, t0);
            check($sformatf("v%0d_writes", v), log_q.size() - base, tbl[v].exp_writes);
            if (tbl[v].exp_writes > 0 && log_q.size() > base) begin
                check($sformatf("v%0d_wa", v), int'(log_q[base].wa), int'(tbl[v].exp_wa));
                check($sformatf("v%0d_wv", v), int'(log_q[base].wv), int'(tbl[v].exp_wv));
                check($sformatf("v%0d_latency", v), log_q[base].cyc - t0, LAT);
            end
            check($sformatf("v%0d_cursor", v), int'(cursor), int'(tbl[v].exp_cursor));
            check($sformatf("v%0d_busy", v), busy_cnt - bbase, 0);
            exp_cursor = int'(tbl[v].exp_cursor);
            $display("txn v%0d: key%0d sw=%03h writes=%0d cursor=%0d",
                     v, tbl[v].key, tbl[v].sw, log_q.size() - base, cursor);
        end

        // Fill sweep with a KEY0 press landing mid-sweep.
        base  = log_q.size();
        bbase = busy_cnt;
        @(negedge clk);
        sw       = 10'h155;
        key_n[3] = 1'b0;
        t0       = cyc;
        wait_until(t0 + 10);
        key_n[3] = 1'b1;
        wait_until(t0 + 20);
        key_n[0] = 1'b0;
        wait_until(t0 + 30);
        key_n[0] = 1'b1;
        wait_until(t0 + 100);
        check_sweep("fill", base, t0, 9'h155);
        check("fill_busy_cycles", busy_cnt - bbase, 64);
        check("fill_cursor", int'(cursor), exp_cursor);
        $display("txn fill: writes=%0d busy=%0d cursor=%0d",
                 log_q.size() - base, busy_cnt - bbase, cursor);

        // KEY2 and KEY0 together: clear wins, write dropped.
        base  = log_q.size();
        bbase = busy_cnt;
        @(negedge clk);
        sw    = 10'h1FF;
        key_n = 4'b1010;
        t0    = cyc;
        wait_until(t0 + 10);
        key_n = 4'hF;
        wait_until(t0 + 100);
        check_sweep("clear", base, t0, 9'h000);
        check("clear_busy_cycles", busy_cnt - bbase, 64);
        check("clear_cursor", int'(cursor), exp_cursor);
        $display("txn clear: writes=%0d busy=%0d cursor=%0d",
                 log_q.size() - base, busy_cnt - bbase, cursor);

        // Reset during the wa=20 write of a fill sweep.
        base  = log_q.size();
        bbase = busy_cnt;
        @(negedge clk);
        sw       = 10'h0AA;
        key_n[3] = 1'b0;
        t0       = cyc;
        wait_until(t0 + 10);
        key_n[3] = 1'b1;
        wait_until(t0 + LAT + 20);
        check("rst_pre_we", int'(we), 1);
        check("rst_pre_wa", int'(wa), 20);
        rst = 1'b1;
        @(negedge clk);
        check("rst_we", int'(we), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cursor", int'(cursor), 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("rst_total_writes", log_q.size() - base, 21);
        check("rst_busy_cycles", busy_cnt - bbase, 21);
        $display("txn rst_mid_sweep: writes=%0d cursor=%0d", log_q.size() - base, cursor);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
